// File: rtl/result_bus_arbiter_pkg.sv
// Shared constants for the CDB write-result stage: ROB tag width, source ids, default sizing.
package result_bus_arbiter_pkg;

  localparam int unsigned ROB_ENTRY_WIDTH = 6;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_BRA = 1;
  localparam int unsigned SRC_LSQ = 2;

  localparam int unsigned CDB_DATA_W     = 32;
  localparam int unsigned CDB_NUM_SRC    = 3;
  localparam int unsigned CDB_FIFO_DEPTH = 2;

  // Index width that stays at least one bit for a single-entry range
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_bus_arbiter_fifo.sv
// Per-source result queue: power-of-two depth, synchronous active-low reset and flush.
module result_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Write-result stage: queues FU results per source and broadcasts one per cycle
// on the CDB in round-robin order; flushed entirely on rollback.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = CDB_DATA_W,
  parameter int unsigned TAG_W      = ROB_ENTRY_WIDTH,
  parameter int unsigned NUM_SRC    = CDB_NUM_SRC,
  parameter int unsigned FIFO_DEPTH = CDB_FIFO_DEPTH,
  localparam int unsigned SRC_W     = idx_w(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rollback,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int unsigned ENT_W = DATA_W + TAG_W;

  logic [NUM_SRC-1:0] push, pop, empty, full;
  logic [ENT_W-1:0]   head [NUM_SRC];

  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

  // Acceptance looks only at registered occupancy; a same-cycle pop does not free a slot
  assign src_ready = {NUM_SRC{rst & ~rollback}} & ~full;
  assign push      = src_valid & src_ready;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign pop[i] = grant_vld & ~rollback & (grant_idx == SRC_W'(i));

    result_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .flush_i (rollback),
      .push_i  (push[i]),
      .data_i  ({src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]}),
      .pop_i   (pop[i]),
      .head_o  (head[i]),
      .empty_o (empty[i]),
      .full_o  (full[i])
    );
  end

  // Round-robin search starting one past the last granted source
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(rr_ptr_q) + k) % NUM_SRC;
      if (!grant_vld && !empty[SRC_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(cand);
      end
    end
  end

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_data_d  = cdb_data_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_src_d   = cdb_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (!rollback && grant_vld) begin
      cdb_valid_d             = 1'b1;
      {cdb_tag_d, cdb_data_d} = head[grant_idx];
      cdb_src_d               = grant_idx;
      rr_ptr_d                = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_tag_q   <= '0;
      cdb_src_q   <= '0;
      rr_ptr_q    <= SRC_W'(NUM_SRC - 1);
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_src_q   <= cdb_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: directed vector table, corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  localparam int DW = 32;
  localparam int TW = ROB_ENTRY_WIDTH;
  localparam int NS = 3;
  localparam int SW = 2;

  typedef logic [TW+DW-1:0] ent_t;

  typedef struct {
    logic          rst;
    logic          rb;
    logic [2:0]    v;
    logic [TW-1:0] t0, t1, t2;
    logic [DW-1:0] d0, d1, d2;
    logic [2:0]    e_rdy;
    logic          e_cv;
    logic [DW-1:0] e_data;
    logic [TW-1:0] e_tag;
    logic [SW-1:0] e_src;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             rollback;
  logic [NS-1:0]    src_valid;
  logic [NS-1:0]    src_ready;
  logic [NS*DW-1:0] src_data;
  logic [NS*TW-1:0] src_tag;
  logic             cdb_valid;
  logic [DW-1:0]    cdb_data;
  logic [TW-1:0]    cdb_tag;
  logic [SW-1:0]    cdb_src;

  always #5 clk = ~clk;

  result_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .rollback  (rollback),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_data  (src_data),
    .src_tag   (src_tag),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  ent_t          mq [NS][$];
  int            m_ptr = NS - 1;
  logic          m_cv = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [TW-1:0] m_tag = '0;
  logic [SW-1:0] m_src = '0;
  logic [NS-1:0] m_rdy;
  logic [NS-1:0] rdy_seen;

  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_valid[i]          = v;
    src_tag[i*TW +: TW]   = t;
    src_data[i*DW +: DW]  = d;
  endtask

  function automatic void model_edge();
    int g;
    ent_t e;
    g = -1;
    if (!rst) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_ptr  = NS - 1;
      m_cv   = 1'b0;
      m_data = '0;
      m_tag  = '0;
      m_src  = '0;
    end else if (rollback) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_cv = 1'b0;
    end else begin
      for (int k = 1; k <= NS; k++) begin
        int s;
        s = (m_ptr + k) % NS;
        if (g < 0 && mq[s].size() > 0) g = s;
      end
      m_cv = (g >= 0);
      if (g >= 0) begin
        e      = mq[g].pop_front();
        m_tag  = e[TW+DW-1:DW];
        m_data = e[DW-1:0];
        m_src  = SW'(g);
        m_ptr  = g;
      end
      for (int i = 0; i < NS; i++)
        if (src_valid[i] && m_rdy[i])
          mq[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
    end
  endfunction

  // One clock: ready checked before the edge, CDB checked just after it
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NS; i++) m_rdy[i] = rst && !rollback && (mq[i].size() < 2);
    rdy_seen = src_ready;
    chk("src_ready", 64'(rdy_seen), 64'(m_rdy));
    @(posedge clk);
    model_edge();
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_cv));
    if (m_cv) begin
      chk("cdb_data", 64'(cdb_data), 64'(m_data));
      chk("cdb_tag", 64'(cdb_tag), 64'(m_tag));
      chk("cdb_src", 64'(cdb_src), 64'(m_src));
    end
  endtask

  function automatic vec_t mkv(input logic r, input logic b, input logic [2:0] v,
                               input logic [TW-1:0] t0, input logic [TW-1:0] t1, input logic [TW-1:0] t2,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                               input logic [2:0] er, input logic ecv, input logic [DW-1:0] ed,
                               input logic [TW-1:0] et, input logic [SW-1:0] es);
    vec_t x;
    x.rst = r; x.rb = b; x.v = v;
    x.t0 = t0; x.t1 = t1; x.t2 = t2;
    x.d0 = d0; x.d1 = d1; x.d2 = d2;
    x.e_rdy = er; x.e_cv = ecv; x.e_data = ed; x.e_tag = et; x.e_src = es;
    return x;
  endfunction

  initial begin
    int   prev;
    int   gcnt;
    logic exp_v;
    logic [SW-1:0] s_alu, s_bra, s_lsq;

    s_alu = SW'(SRC_ALU);
    s_bra = SW'(SRC_BRA);
    s_lsq = SW'(SRC_LSQ);

    rst       = 1'b0;
    rollback  = 1'b0;
    src_valid = '0;
    src_data  = '0;
    src_tag   = '0;

    // Reset held with all valid, single result, reset again, simultaneous offers
    vt[0]  = mkv(1'b0, 1'b0, 3'b111, 6'd1, 6'd2, 6'd3, 32'h11, 32'h22, 32'h33, 3'b000, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[1]  = mkv(1'b0, 1'b0, 3'b111, 6'd1, 6'd2, 6'd3, 32'h11, 32'h22, 32'h33, 3'b000, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[2]  = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[3]  = mkv(1'b1, 1'b0, 3'b001, 6'd5, 6'd0, 6'd0, 32'hDEADBEEF, 32'h0, 32'h0, 3'b111, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[4]  = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b1, 32'hDEADBEEF, 6'd5, s_alu);
    vt[5]  = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[6]  = mkv(1'b0, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[7]  = mkv(1'b1, 1'b0, 3'b111, 6'd1, 6'd2, 6'd3, 32'h11, 32'h22, 32'h33, 3'b111, 1'b0, 32'h0, 6'd0, 2'd0);
    vt[8]  = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b1, 32'h11, 6'd1, s_alu);
    vt[9]  = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b1, 32'h22, 6'd2, s_bra);
    vt[10] = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b1, 32'h33, 6'd3, s_lsq);
    vt[11] = mkv(1'b1, 1'b0, 3'b000, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 32'h0, 3'b111, 1'b0, 32'h0, 6'd0, 2'd0);

    for (int r = 0; r < 12; r++) begin
      rst      = vt[r].rst;
      rollback = vt[r].rb;
      set_src(0, vt[r].v[0], vt[r].t0, vt[r].d0);
      set_src(1, vt[r].v[1], vt[r].t1, vt[r].d1);
      set_src(2, vt[r].v[2], vt[r].t2, vt[r].d2);
      tick();
      chk($sformatf("row%0d_ready", r), 64'(rdy_seen), 64'(vt[r].e_rdy));
      chk($sformatf("row%0d_cv", r), 64'(cdb_valid), 64'(vt[r].e_cv));
      if (vt[r].e_cv) begin
        chk($sformatf("row%0d_data", r), 64'(cdb_data), 64'(vt[r].e_data));
        chk($sformatf("row%0d_tag", r), 64'(cdb_tag), 64'(vt[r].e_tag));
        chk($sformatf("row%0d_src", r), 64'(cdb_src), 64'(vt[r].e_src));
      end
    end

    // Fairness: all sources valid for 12 cycles, grants must rotate 0,1,2,...
    prev = 2;
    gcnt = 0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NS; i++) set_src(i, 1'b1, TW'(c * 3 + i), $urandom);
      tick();
      if (cdb_valid) begin
        chk("rr_order", 64'(cdb_src), 64'((prev + 1) % 3));
        prev = int'(cdb_src);
        gcnt++;
      end
    end
    chk("rr_grant_count", 64'(gcnt), 64'd11);

    // Rollback with queues full; src0 offers tag 7 during the flush
    rollback = 1'b1;
    set_src(0, 1'b1, 6'd7, 32'h7777_7777);
    tick();
    chk("rb_ready", 64'(rdy_seen), 64'b000);
    chk("rb_cv", 64'(cdb_valid), 64'd0);
    rollback  = 1'b0;
    src_valid = '0;
    tick();
    chk("post_rb_ready", 64'(rdy_seen), 64'b111);
    chk("post_rb_cv", 64'(cdb_valid), 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("no_tag7", 64'(cdb_valid), 64'd0);
    end

    // Streaming: src2 sends tags 0..5 back to back
    src_valid = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < 6) set_src(2, 1'b1, TW'(j), 32'hA500_0000 + 32'(j));
      else       src_valid = '0;
      tick();
      if (j < 6) chk("stream_ready2", 64'(rdy_seen[2]), 64'd1);
      exp_v = (j >= 1) && (j <= 6);
      chk("stream_cv", 64'(cdb_valid), 64'(exp_v));
      if (exp_v) begin
        chk("stream_tag", 64'(cdb_tag), 64'(j - 1));
        chk("stream_src", 64'(cdb_src), 64'(s_lsq));
      end
    end

    // Randomized traffic with occasional rollback and reset
    for (int n = 0; n < 2000; n++) begin
      rst       = ($urandom_range(99) != 0);
      rollback  = ($urandom_range(19) == 0);
      src_valid = 3'($urandom);
      src_data  = {$urandom, $urandom, $urandom};
      src_tag   = 18'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
